mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute ALU. Consumes the 16-bit ALU result plus ld/st
//  decode bits each accepted op, performs the data-memory access over a req/gnt/rvalid bus for
//  loads/stores, and emits one writeback record per completed op to the register-file stage.
//  Stalls upstream (in_ready low) while a memory transaction is outstanding.
// PARAMETERS
//  DATA_W   16   datapath width (ALU result, store data, load data)
//  ADDR_W   16   memory address width; mem_addr = in_aluresult[ADDR_W-1:0]
//  RD_W     3    destination register index width (8 registers)
//  TIMEOUT  255  cycles a transaction may stay in REQ+WAIT before abort (MEM_TIMEOUT_EN only)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       asynchronous active-low reset
//  in_valid      in   1       upstream op valid this cycle
//  in_ready      out  1       stage can accept; high only in IDLE
//  in_isld       in   1       op is a load (address = in_aluresult)
//  in_isst       in   1       op is a store (address = in_aluresult)
//  in_wben       in   1       op writes a register (loads and ALU ops; never stores)
//  in_rd         in   RD_W    destination register index
//  in_aluresult  in   DATA_W  ALU result / effective address
//  in_stdata     in   DATA_W  store data
//  mem_req       out  1       memory request, held until mem_gnt
//  mem_we        out  1       1 = write, 0 = read; valid while mem_req
//  mem_addr      out  ADDR_W  request address, stable while mem_req
//  mem_wdata     out  DATA_W  store data, stable while mem_req
//  mem_gnt       in   1       request accepted this cycle
//  mem_rvalid    in   1       read data valid this cycle
//  mem_rdata     in   DATA_W  read data
//  wb_valid      out  1       one-cycle writeback pulse
//  wb_rd         out  RD_W    writeback register index
//  wb_data       out  DATA_W  writeback data
//  err           out  1       one-cycle pulse on transaction abort (tied 0 without MEM_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, wb_valid, err = 0; mem_addr, mem_wdata,
//    wb_rd, wb_data = 0; timeout counter = 0. Outstanding transaction is dropped, no writeback.
//  - Accept = in_valid & in_ready. Inputs are captured into internal registers on accept only.
//  - in_isld and in_isst both set: treated as load (load has priority).
//  - ALU op (neither ld nor st): stays IDLE; next cycle wb_valid = in_wben, wb_rd = in_rd,
//    wb_data = in_aluresult. Latency 1, throughput 1 op/cycle.
//  - FSM IDLE -> REQ on accepted ld/st; mem_req asserted from the cycle after accept.
//    REQ: hold mem_req/mem_we/mem_addr/mem_wdata stable until mem_gnt sampled high.
//      store + gnt -> IDLE; wb_valid stays 0 (stores never write back).
//      load + gnt + rvalid same cycle -> IDLE, writeback next cycle (zero-latency memory).
//      load + gnt, no rvalid -> WAIT.
//    WAIT: mem_req = 0; on mem_rvalid -> IDLE; next cycle wb_valid=1, wb_rd=captured rd,
//      wb_data=mem_rdata.
//  - mem_req deasserts the cycle after gnt. in_ready rises in the cycle after completion.
//  - mem_rvalid outside a load's REQ/WAIT is ignored. mem_gnt while mem_req=0 is ignored.
//  - wb_valid is a single-cycle pulse; wb_rd/wb_data hold their last value otherwise.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: 8-bit-min counter clears on entering REQ, increments each REQ/WAIT
//    cycle; when it reaches TIMEOUT with no completion: mem_req drops, state -> IDLE, err pulses
//    1 cycle, no writeback. Completion in the same cycle as reaching TIMEOUT wins (no err).
//  Not defined: no counter; REQ/WAIT wait indefinitely; err tied 0.
// STRUCTURE
//  Shared package cpu_pkg: DATA_W/ADDR_W/RD_W constants, mem_state_t enum {IDLE, REQ, WAIT},
//    alusignals bit-index constants (ISADD..ISLSR) shared with the execute stage.
//  One sub-module: mem_timeout_ctr (clear/enable/expired), instantiated only under MEM_TIMEOUT_EN.
// TESTING
//  1 ALU op: in_aluresult=16'h1234, rd=3, wben=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=16'h1234.
//  2 Load, gnt after 2 cycles, rvalid 3 cycles later, rdata=16'hBEEF, rd=5 -> mem_req high 3 cycles,
//    addr stable, wb_data=16'hBEEF rd=5 one cycle after rvalid; in_ready low throughout.
//  3 Store addr=16'h0040 data=16'hA5A5, gnt immediate -> one mem_req cycle, mem_we=1, no wb_valid.
//  4 Load with gnt and rvalid same cycle, rdata=16'h0007 -> writeback next cycle, no WAIT state.
//  5 rst_n low while in WAIT -> mem_req/wb_valid 0 immediately; later rvalid ignored; in_ready=1.
//  6 MEM_TIMEOUT_EN, TIMEOUT=8, gnt never -> err pulses once after 8 REQ cycles, no wb, in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory-stage FSM states and execute-stage alusignals bit indices
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int RD_W = 3;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
  localparam int ISADD = 0;
  localparam int ISSUB = 1;
  localparam int ISAND = 2;
  localparam int ISOR = 3;
  localparam int ISXOR = 4;
  localparam int ISNOT = 5;
  localparam int ISLSL = 6;
  localparam int ISLSR = 7;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: transaction age counter; clear restarts, en counts, expired flags the LIMIT-th counted cycle
module mem_timeout_ctr #(
  parameter int W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage; ALU ops write back after 1 cycle, ld/st go over req/gnt/rvalid (MEM_TIMEOUT_EN adds abort)
import cpu_pkg::*;
module mem_access_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
`ifdef MEM_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  parameter int RD_W = cpu_pkg::RD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_isld,
  input  logic              in_isst,
  input  logic              in_wben,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_aluresult,
  input  logic [DATA_W-1:0] in_stdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);
  mem_state_t state, state_d;
  logic accept, ld_q, wb_alu, wb_mem, expired;
  logic [RD_W-1:0] rd_q;
  assign in_ready = state == IDLE;
  assign mem_req = state == REQ;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // completion is checked before expiry so a same-cycle finish never aborts
  always_comb begin
    state_d = state;
    wb_alu = 1'b0;
    wb_mem = 1'b0;
    case (state)
      IDLE: begin
        state_d = accept && (in_isld || in_isst) ? REQ : IDLE;
        wb_alu = accept && !in_isld && !in_isst && in_wben;
      end
      REQ: begin
        state_d = mem_gnt ? (ld_q && !mem_rvalid ? WAIT : IDLE) : expired ? IDLE : REQ;
        wb_mem = mem_gnt && ld_q && mem_rvalid;
      end
      WAIT: begin
        state_d = mem_rvalid || expired ? IDLE : WAIT;
        wb_mem = mem_rvalid;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ld_q <= 1'b0;
      rd_q <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        ld_q <= in_isld;
        rd_q <= in_rd;
        mem_we <= !in_isld && in_isst;
        mem_addr <= in_aluresult[ADDR_W-1:0];
        mem_wdata <= in_stdata;
      end
      wb_valid <= wb_alu || wb_mem;
      if (wb_alu || wb_mem) begin
        wb_rd <= wb_alu ? in_rd : rd_q;
        wb_data <= wb_alu ? in_aluresult : mem_rdata;
      end
    end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) < 8 ? 8 : $clog2(TIMEOUT + 1);
  logic abort;
  assign abort = expired && (state == REQ ? !mem_gnt : !mem_rvalid);
  mem_timeout_ctr #(.W(CW), .LIMIT(TIMEOUT)) u_timeout (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state == IDLE && state_d == REQ),
    .en(state != IDLE),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else err <= abort;
`else
  assign expired = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of ALU writeback, load/store handshakes, async reset and optional timeout
module tb_mem_access_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_ready, in_isld = 0, in_isst = 0, in_wben = 0;
  logic [2:0] in_rd = '0, wb_rd;
  logic [15:0] in_aluresult = '0, in_stdata = '0, mem_addr, mem_wdata, mem_rdata = '0, wb_data;
  logic mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0, wb_valid, err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_access_stage #(
`ifdef MEM_TIMEOUT_EN
    .TIMEOUT(8),
`endif
    .DATA_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_isld(in_isld),
    .in_isst(in_isst), .in_wben(in_wben), .in_rd(in_rd), .in_aluresult(in_aluresult),
    .in_stdata(in_stdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic ld, input logic st, input logic wben, input logic [2:0] rd,
                       input logic [15:0] alu, input logic [15:0] sd);
    in_valid = 1; in_isld = ld; in_isst = st; in_wben = wben; in_rd = rd;
    in_aluresult = alu; in_stdata = sd;
  endtask
  initial begin
    #12;
    chk("rst_req", mem_req, 0);
    chk("rst_wb", {wb_valid, err}, 0);
    chk("rst_regs", {mem_addr, wb_data}, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1;
    step();
    issue(0, 0, 1, 3, 16'h1234, 0);
    step();
    in_valid = 0;
    chk("alu_wbv", wb_valid, 1);
    chk("alu_wb", {wb_rd, wb_data}, {3'd3, 16'h1234});
    chk("alu_noreq", mem_req, 0);
    step();
    chk("alu_pulse", wb_valid, 0);
    issue(0, 0, 1, 1, 16'h1111, 0);
    step();
    issue(0, 0, 1, 2, 16'h2222, 0);
    chk("b2b_a", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd1, 16'h1111});
    step();
    issue(0, 0, 0, 7, 16'h3333, 0);
    chk("b2b_b", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd2, 16'h2222});
    step();
    in_valid = 0;
    chk("nowben", {wb_valid, wb_rd, wb_data}, {1'b0, 3'd2, 16'h2222});
    issue(1, 0, 1, 5, 16'h0100, 16'h9999);
    step();
    in_valid = 0;
    in_aluresult = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0100});
      chk("ld_rdy", in_ready, 0);
      mem_gnt = i == 2;
      step();
    end
    mem_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait", {mem_req, in_ready, wb_valid}, 0);
      if (i == 2) begin mem_rvalid = 1; mem_rdata = 16'hBEEF; end
      step();
    end
    mem_rvalid = 0;
    chk("ld_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd5, 16'hBEEF});
    chk("ld_ready", {in_ready, mem_req}, 2'b10);
    step();
    chk("ld_pulse", wb_valid, 0);
    issue(0, 1, 0, 4, 16'h0040, 16'hA5A5);
    step();
    in_valid = 0;
    chk("st_req", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0040, 16'hA5A5});
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("st_done", {mem_req, wb_valid, in_ready}, 3'b001);
    issue(1, 1, 1, 6, 16'h0200, 16'h5555);
    step();
    in_valid = 0;
    chk("ldst_pri", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0200});
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 16'h0007;
    step();
    mem_gnt = 0; mem_rvalid = 0;
    chk("zl_wb", {wb_valid, wb_rd, wb_data}, {1'b1, 3'd6, 16'h0007});
    chk("zl_idle", {mem_req, in_ready}, 2'b01);
    mem_rvalid = 1; mem_rdata = 16'hFFFF; mem_gnt = 1;
    step();
    mem_rvalid = 0; mem_gnt = 0;
    chk("idle_ign", {wb_valid, wb_data, in_ready}, {1'b0, 16'h0007, 1'b1});
    issue(1, 0, 1, 4, 16'h0300, 0);
    step();
    in_valid = 0;
    mem_gnt = 1;
    step();
    mem_gnt = 0;
    chk("rst_pre", {mem_req, in_ready}, 2'b00);
    rst_n = 0;
    #1;
    chk("arst", {mem_req, wb_valid, in_ready, wb_data}, {3'b001, 16'h0000});
    @(negedge clk);
    rst_n = 1;
    mem_rvalid = 1; mem_rdata = 16'h4444;
    step();
    mem_rvalid = 0;
    chk("arst_ign", {wb_valid, wb_data, in_ready}, {1'b0, 16'h0000, 1'b1});
`ifdef MEM_TIMEOUT_EN
    begin
      int n = 0;
      issue(1, 0, 1, 2, 16'h0500, 0);
      step();
      in_valid = 0;
      while (mem_req && n < 20) begin
        n++;
        chk("to_noerr", err, 0);
        step();
      end
      chk("to_cycles", n, 8);
      chk("to_err", {err, wb_valid, in_ready, mem_req}, 4'b1010);
      step();
      chk("to_pulse", err, 0);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
